x_ddr_tx_serializer: RTL and testbench
======================================

Name: x_ddr_tx_serializer

Overview:
Parallel-to-serial dual-data-rate transmitter. It drives one data bit per CLK phase: one bit while CLK is high, the next while CLK is low. It is the sending end of the dual-edge capture path, feeding our dual-edge D flip-flop primitives, which sample on both CLK edges. It accepts WIDTH-bit words over a valid/ready handshake and streams them MSB-first with no gaps when words arrive back-to-back.

Parameters:
WIDTH, 8, word width in bits; must be even and at least 2.
IDLE_LEVEL, 1'b0, value driven on O in both CLK phases when no word is in flight.

Ports:
CLK  input  1  sole clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-low reset.
CE  input  1  clock enable; low freezes all state.
DIN  input  WIDTH  parallel word to transmit.
DIN_VALID  input  1  DIN holds a word.
DIN_READY  output  1  block accepts DIN at the next rising edge.
O  output  1  DDR serial data.
FRAME  output  1  high for every CLK cycle that carries word bits.

Behaviour:
- Reset is asynchronous and active-low (RST=0). Effect, immediately and independent of CLK:
  - state=IDLE, shift register=0, pair counter=0.
  - O=IDLE_LEVEL, FRAME=0, DIN_READY=0.
- After RST deasserts with state IDLE: DIN_READY=1 combinationally.
- State machine, two states: IDLE and SHIFT.
- Word accept: happens at a rising edge where RST=1, CE=1, DIN_VALID=1 and DIN_READY=1.
  - DIN loads into the shift register.
  - Counter loads WIDTH/2-1.
  - State becomes SHIFT.
- DIN_READY = RST & CE & (state==IDLE | counter==0). It is combinational, so a next word can be accepted on the last pair cycle.
- Latency: the first bit pair appears on O in the CLK cycle that begins at the accepting edge. There is zero bubble.
- Output timing in SHIFT, for pair j (j=0..WIDTH/2-1):
  - CLK high phase: O = word bit WIDTH-1-2j.
  - CLK low phase: O = word bit WIDTH-2-2j.
  - O is a registered-bit pair muxed by CLK level.
  - A receiver captures the high-phase bit on the falling edge and the low-phase bit on the next rising edge.
- Each rising edge with CE=1 in SHIFT:
  - Shift the register left by 2.
  - Decrement the counter.
  - When the counter is 0: if a new word is accepted, stay in SHIFT and reload; otherwise go to IDLE.
- FRAME=1 exactly while state==SHIFT. It is registered and changes only at rising edges (or on reset).
- IDLE: O=IDLE_LEVEL in both phases, FRAME=0.
- CE=0 freezes everything:
  - State, counter and shift register hold.
  - O keeps repeating the current bit pair each cycle.
  - FRAME holds.
  - DIN_READY=0, so no accept.
- DIN_VALID with DIN_READY=0: ignored. There is no internal buffering; the upstream holds DIN.
- Reset mid-word: the partial word is discarded and O returns to IDLE_LEVEL asynchronously. No bits resume after release.
- DIN is sampled only at the accept edge; later changes on DIN have no effect.
- Counter width is clog2(WIDTH/2), minimum 1. There is no wrap-around beyond reload.

Test Plan:
1. Reset and idle: hold RST=0 for 3 cycles, then release with DIN_VALID=0 -> O=0, FRAME=0 during reset; DIN_READY=0 during reset and 1 after release; O stays 0 in both phases.
2. Single word: DIN=8'hA5 accepted -> 4 FRAME cycles with O high/low phases 1/0, 1/0, 0/1, 0/1; DIN_READY=0 on cycles 1-3 and 1 on cycle 4; afterwards O=0 and FRAME=0.
3. Back-to-back: 8'hF0 then 8'h0F, DIN_VALID held high -> second word accepted on cycle 4; FRAME high for 8 contiguous cycles; serial stream 1111000000001111 with no idle bits.
4. CE stall: 8'h3C with CE=0 for 2 cycles after pair 1 -> pair 0,0 then 1,1 repeated for the 2 stall cycles; total 6 FRAME cycles; recovered bits still 00111100; DIN_READY=0 while stalled.
5. Reset mid-word: 8'hFF, RST pulsed low during pair 2 high phase -> O drops to 0 and FRAME=0 immediately; after release DIN_READY=1 and no further 1 bits appear.
6. Loopback: O drives a dual-edge capture flop clocked by CLK, 200 random words with random DIN_VALID gaps and CE stalls -> every word is recovered bit-exact in order.

Source files
------------

// File: rtl/x_ddr_tx_serializer.sv
// Parallel-to-serial DDR transmitter.
// Accepts WIDTH-bit words over valid/ready and sends them MSB-first as one
// bit per CLK phase: the high-phase bit while CLK=1, the low-phase bit while
// CLK=0. Back-to-back words stream without idle bits because the next word
// can be accepted on the last pair cycle of the current one.
module x_ddr_tx_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             O,
    output logic             FRAME
);

    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(PAIRS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             accept;

    // Ready is combinational so the next word can land on the last pair cycle.
    always_comb begin
        DIN_READY = RST & CE & ((state_q == S_IDLE) | (cnt_q == '0));
        accept    = DIN_READY & DIN_VALID;
    end

    // Next-state logic: load on accept, otherwise shift by one pair per enabled edge.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (CE) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_SHIFT;
                        shreg_d = DIN;
                        cnt_d   = CNT_LOAD;
                    end
                end
                S_SHIFT: begin
                    shreg_d = shreg_q << 2;
                    if (cnt_q == '0) begin
                        if (accept) begin
                            shreg_d = DIN;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers; reset clears any word in flight immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // FRAME is the decoded state flop; O muxes the current registered pair by CLK level.
    always_comb begin
        FRAME = (state_q == S_SHIFT);
        if (state_q == S_SHIFT) begin
            O = CLK ? shreg_q[WIDTH-1] : shreg_q[WIDTH-2];
        end else begin
            O = IDLE_LEVEL;
        end
    end

endmodule

// File: tb/tb_x_ddr_tx_serializer.sv
// Directed and loopback bench for the DDR transmitter (WIDTH=8, IDLE_LEVEL=0).
// Inputs change in the CLK low phase; the high-phase bit is sampled 1ns after
// the rising edge and the low-phase bit 1ns after the falling edge.
module tb_x_ddr_tx_serializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CE = 1'b1;
    logic [7:0] DIN = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY;
    logic       O;
    logic       FRAME;

    int checks = 0;
    int errors = 0;

    x_ddr_tx_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .O         (O),
        .FRAME     (FRAME)
    );

    always #5 CLK = ~CLK;

    // One CLK cycle: capture both phases of O and FRAME; returns in the low phase.
    task automatic step(output logic hi, output logic lo, output logic fr);
        @(posedge CLK);
        #1;
        hi = O;
        fr = FRAME;
        @(negedge CLK);
        #1;
        lo = O;
    endtask

    task automatic test_reset();
        logic hi, lo, fr;
        for (int k = 0; k < 3; k++) begin
            step(hi, lo, fr);
            #1;
            checks++;
            if (hi !== 1'b0 || lo !== 1'b0 || fr !== 1'b0 || DIN_READY !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: O=%b/%b FRAME=%b RDY=%b required 0/0 0 0",
                         k, hi, lo, fr, DIN_READY);
            end
        end
        RST = 1'b1;
        #1;
        checks++;
        if (DIN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: RDY=%b required 1", DIN_READY);
        end
        for (int k = 0; k < 2; k++) begin
            step(hi, lo, fr);
            checks++;
            if (hi !== 1'b0 || lo !== 1'b0 || fr !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc%0d: O=%b/%b FRAME=%b required 0/0 0", k, hi, lo, fr);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic hi, lo, fr;
        logic [7:0] w;
        w = 8'hA5;
        DIN = w;
        DIN_VALID = 1'b1;
        #1;
        checks++;
        if (DIN_READY !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_idle: RDY=%b required 1", DIN_READY);
        end
        for (int j = 0; j < 4; j++) begin
            step(hi, lo, fr);
            DIN_VALID = 1'b0;
            #1;
            checks++;
            if (hi !== w[7-2*j] || lo !== w[6-2*j] || fr !== 1'b1 || DIN_READY !== (j == 3)) begin
                errors++;
                $display("FAIL single pair%0d: O=%b/%b FRAME=%b RDY=%b required %b/%b 1 %b",
                         j, hi, lo, fr, DIN_READY, w[7-2*j], w[6-2*j], (j == 3));
            end
        end
        step(hi, lo, fr);
        checks++;
        if (hi !== 1'b0 || lo !== 1'b0 || fr !== 1'b0) begin
            errors++;
            $display("FAIL single_after: O=%b/%b FRAME=%b required 0/0 0", hi, lo, fr);
        end
        $display("test_single word=%h done", w);
    endtask

    task automatic test_back_to_back();
        logic hi, lo, fr;
        logic [15:0] w;
        w = 16'hF00F;
        DIN = 8'hF0;
        DIN_VALID = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(hi, lo, fr);
            if (k == 0) DIN = 8'h0F;
            if (k == 4) DIN_VALID = 1'b0;
            #1;
            checks++;
            if (hi !== w[15-2*k] || lo !== w[14-2*k] || fr !== 1'b1 ||
                DIN_READY !== (k == 3 || k == 7)) begin
                errors++;
                $display("FAIL b2b cyc%0d: O=%b/%b FRAME=%b RDY=%b required %b/%b 1 %b",
                         k, hi, lo, fr, DIN_READY, w[15-2*k], w[14-2*k], (k == 3 || k == 7));
            end
        end
        step(hi, lo, fr);
        checks++;
        if (hi !== 1'b0 || lo !== 1'b0 || fr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after: O=%b/%b FRAME=%b required 0/0 0", hi, lo, fr);
        end
        $display("test_back_to_back F0,0F done");
    endtask

    task automatic test_ce_stall();
        logic hi, lo, fr;
        logic [5:0] epair;
        logic [7:0] rx;
        logic ce_edge;
        epair = 6'b011110;   // per cycle: 00,11,11(stall),11(stall),11,00
        rx = 8'h00;
        DIN = 8'h3C;
        DIN_VALID = 1'b1;
        ce_edge = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(hi, lo, fr);
            if (ce_edge) rx = {rx[5:0], hi, lo};
            DIN_VALID = 1'b0;
            CE = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            ce_edge = CE;
            #1;
            checks++;
            if (hi !== epair[k] || lo !== epair[k] || fr !== 1'b1 || DIN_READY !== (k == 5)) begin
                errors++;
                $display("FAIL stall cyc%0d: O=%b/%b FRAME=%b RDY=%b required %b/%b 1 %b",
                         k, hi, lo, fr, DIN_READY, epair[k], epair[k], (k == 5));
            end
        end
        step(hi, lo, fr);
        checks++;
        if (fr !== 1'b0 || hi !== 1'b0 || lo !== 1'b0) begin
            errors++;
            $display("FAIL stall_after: O=%b/%b FRAME=%b required 0/0 0", hi, lo, fr);
        end
        checks++;
        if (rx !== 8'h3C) begin
            errors++;
            $display("FAIL stall_recovered: got %h required 3c", rx);
        end
        $display("test_ce_stall word=3c done");
    endtask

    task automatic test_reset_mid();
        logic hi, lo, fr;
        DIN = 8'hFF;
        DIN_VALID = 1'b1;
        step(hi, lo, fr);
        DIN_VALID = 1'b0;
        step(hi, lo, fr);
        @(posedge CLK);
        #1;
        checks++;
        if (O !== 1'b1 || FRAME !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: O=%b FRAME=%b required 1 1", O, FRAME);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (O !== 1'b0 || FRAME !== 1'b0 || DIN_READY !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: O=%b FRAME=%b RDY=%b required 0 0 0", O, FRAME, DIN_READY);
        end
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        checks++;
        if (DIN_READY !== 1'b1) begin
            errors++;
            $display("FAIL mid_release_ready: RDY=%b required 1", DIN_READY);
        end
        for (int k = 0; k < 4; k++) begin
            step(hi, lo, fr);
            checks++;
            if (hi !== 1'b0 || lo !== 1'b0 || fr !== 1'b0) begin
                errors++;
                $display("FAIL mid_after cyc%0d: O=%b/%b FRAME=%b required 0/0 0", k, hi, lo, fr);
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_loopback();
        logic hi, lo, fr, took, ce_edge;
        logic [7:0] q[$];
        logic [7:0] rx, expw;
        int accepted, nb, cyc, words;
        accepted = 0; nb = 0; cyc = 0; words = 0; rx = 8'h00;
        DIN_VALID = 1'b0;
        while ((accepted < 200 || q.size() > 0 || nb != 0) && cyc < 6000) begin
            if (accepted < 200) begin
                if (!DIN_VALID) begin
                    DIN = 8'($urandom);
                    DIN_VALID = ($urandom_range(0, 3) != 0);
                end
            end else begin
                DIN_VALID = 1'b0;
            end
            CE = ($urandom_range(0, 4) != 0);
            #1;
            took = DIN_READY & DIN_VALID;
            if (took) begin
                q.push_back(DIN);
                accepted++;
            end
            ce_edge = CE;
            step(hi, lo, fr);
            cyc++;
            if (took) DIN_VALID = 1'b0;
            if (fr && ce_edge) begin
                rx = {rx[5:0], hi, lo};
                nb += 2;
                if (nb == 8) begin
                    nb = 0;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL loop_extra_word: got %h required none", rx);
                    end else begin
                        expw = q.pop_front();
                        words++;
                        if (rx !== expw) begin
                            errors++;
                            $display("FAIL loop_word%0d: got %h required %h", words, rx, expw);
                        end
                    end
                end
            end
        end
        CE = 1'b1;
        checks++;
        if (cyc >= 6000 || words != 200) begin
            errors++;
            $display("FAIL loop_complete: words %0d in %0d cycles required 200 before 6000",
                     words, cyc);
        end
        $display("test_loopback words=%0d cycles=%0d", words, cyc);
    endtask

    initial begin
        #1;
        checks++;
        if (O !== 1'b0 || FRAME !== 1'b0 || DIN_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: O=%b FRAME=%b RDY=%b required 0 0 0", O, FRAME, DIN_READY);
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_ce_stall();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
